// File: rtl/fetch_pc_sequencer_if.sv
// Fetch sequencer bus bundle: decode-side controls, instruction memory
// handshake and the IF/ID presentation signals.
interface fetch_pc_sequencer_if;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        halted;
  logic [15:0] fetch_count;

  // Sequencer side.
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_valid, imem_data,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus2,
           halted, fetch_count
  );

  // Environment side: decode, PC control and instruction memory.
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_valid, imem_data,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus2,
           halted, fetch_count
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the architectural PC, issues level-handshake
// instruction reads, presents fetched words to decode, applies stalls and
// redirects, and drains the pipe on HLT.
//
// state | meaning
// RST_S | one idle cycle after reset release, no fetch request
// FETCH | requesting words at pc, presenting them to decode
// DRAIN | HLT captured; waiting for decode to accept it, no requests
// HALT  | core halted; only reset leaves this state
module fetch_pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {RST_S, FETCH, DRAIN, HALT} state_t;

  // Instruction addresses are halfword aligned.
  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic [15:0] if_pc_plus2_q, if_pc_plus2_d;
  logic        halted_q, halted_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic imem_req;
  logic accept;
  logic capture;

  // Request and handshake qualifiers; redirect squashes both accept and capture.
  always_comb begin
    imem_req = (state_q == FETCH) && !(if_valid_q && bus.stall);
    accept   = if_valid_q && !bus.stall && !bus.redirect_valid;
    capture  = imem_req && bus.imem_valid && !bus.redirect_valid;
  end

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus2_d = if_pc_plus2_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    if (accept && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    if ((state_q != HALT) && bus.redirect_valid) begin
      // Redirect wins over everything, including a pending HLT in DRAIN.
      pc_d       = bus.redirect_pc & 16'hFFFE;
      if_valid_d = 1'b0;
      state_d    = FETCH;
    end else begin
      case (state_q)
        RST_S: state_d = FETCH;
        FETCH: begin
          if (capture) begin
            // Capture may coincide with accept: the slot is refilled directly.
            if_instr_d    = bus.imem_data;
            if_pc_d       = pc_q;
            if_pc_plus2_d = pc_q + 16'd2;
            if_valid_d    = 1'b1;
            pc_d          = pc_q + 16'd2;
            if (bus.imem_data[15:12] == HALT_OPCODE) begin
              state_d = DRAIN;
            end
          end else if (accept) begin
            if_valid_d = 1'b0;
          end
        end
        DRAIN: begin
          if (accept) begin
            if_valid_d = 1'b0;
            halted_d   = 1'b1;
            state_d    = HALT;
          end
        end
        default: begin
          if_valid_d = 1'b0;
          halted_d   = 1'b1;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RST_S;
      pc_q          <= RESET_PC_ALIGNED;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 16'h0000;
      if_pc_q       <= 16'h0000;
      if_pc_plus2_q <= 16'h0000;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus2_q <= if_pc_plus2_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus2 = if_pc_plus2_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed scenarios followed by
// randomized traffic, all compared against a transaction-level fetch model.
module tb_fetch_pc_sequencer;

  logic clk = 1'b0;
  logic rst;

  fetch_pc_sequencer_if bus ();

  fetch_pc_sequencer #(
    .RESET_PC    (16'h0000),
    .HALT_OPCODE (4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: PC, a one-entry presentation slot, and flags for
  // "fetching has started", "HLT waiting to be taken" and "halted".
  logic [15:0] m_pc, m_instr, m_ipc, m_ipc2, m_count;
  bit          m_valid, m_started, m_hlt_pend, m_halted;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_ipc2 = 16'h0000;
    m_count = 16'h0000; m_valid = 0; m_started = 0; m_hlt_pend = 0; m_halted = 0;
  endtask

  function automatic bit model_req(input bit s);
    return m_started && !m_hlt_pend && !m_halted && !(m_valid && s);
  endfunction

  task automatic check_all(input bit er);
    chk("imem_req",    16'(bus.imem_req), 16'(er));
    chk("imem_addr",   bus.imem_addr, m_pc);
    chk("if_valid",    16'(bus.if_valid), 16'(m_valid));
    chk("if_instr",    bus.if_instr, m_instr);
    chk("if_pc",       bus.if_pc, m_ipc);
    chk("if_pc_plus2", bus.if_pc_plus2, m_ipc2);
    chk("halted",      16'(bus.halted), 16'(m_halted));
    chk("fetch_count", bus.fetch_count, m_count);
  endtask

  // One clock cycle: drive, check at negedge, advance model, land at posedge+1.
  task automatic step(input bit s, input bit rv, input logic [15:0] rpc,
                      input bit iv, input logic [15:0] d);
    bit er;
    bus.stall = s; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    bus.imem_valid = iv; bus.imem_data = d;
    @(negedge clk);
    er = model_req(s);
    check_all(er);
    if (!m_halted) begin
      if (rv) begin
        m_pc = rpc & 16'hFFFE; m_valid = 0; m_hlt_pend = 0;
      end else begin
        if (m_valid && !s) begin
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          m_valid = 0;
          if (m_hlt_pend) begin m_halted = 1; m_hlt_pend = 0; end
        end
        if (er && iv) begin
          m_instr = d; m_ipc = m_pc; m_ipc2 = m_pc + 16'd2; m_valid = 1;
          m_pc = m_pc + 16'd2;
          if (d[15:12] == 4'hF) m_hlt_pend = 1;
        end
      end
      m_started = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 16'h0000;
    bus.imem_valid = 0; bus.imem_data = 16'h0000;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    check_all(1'b0);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] seq_word(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  initial begin
    logic [15:0] d;
    // Sequential fetch.
    do_reset(2);
    repeat (8) step(0, 0, 16'h0, 1, seq_word(m_pc));
    chk("seq_count", bus.fetch_count, 16'd6);
    chk("seq_instr", bus.if_instr, 16'h100C);
    chk("seq_pc2",   bus.if_pc_plus2, 16'h000E);

    // Stall freeze, then memory latency.
    repeat (3) step(1, 0, 16'h0, 1, seq_word(m_pc));
    repeat (4) step(0, 0, 16'h0, 0, 16'hDEAD);
    repeat (3) step(0, 0, 16'h0, 1, seq_word(m_pc));

    // Redirect beats stall, imem_valid and an odd target.
    step(1, 1, 16'h0041, 1, seq_word(m_pc));
    chk("redir_addr",  bus.imem_addr, 16'h0040);
    chk("redir_valid", 16'(bus.if_valid), 16'd0);
    repeat (3) step(0, 0, 16'h0, 1, seq_word(m_pc));

    // HLT at 0x0010, held by stall, then accepted; later redirect ignored.
    step(0, 1, 16'h0010, 0, 16'h0);
    step(0, 0, 16'h0, 1, 16'hF000);
    repeat (2) step(1, 0, 16'h0, 1, seq_word(m_pc));
    step(0, 0, 16'h0, 1, seq_word(m_pc));
    chk("halt_halted", 16'(bus.halted), 16'd1);
    chk("halt_valid",  16'(bus.if_valid), 16'd0);
    step(0, 1, 16'h0100, 1, seq_word(m_pc));
    repeat (2) step(0, 0, 16'h0, 1, seq_word(m_pc));
    chk("halt_req", 16'(bus.imem_req), 16'd0);

    // Speculative HLT cancelled by redirect while draining.
    do_reset(2);
    step(0, 0, 16'h0, 0, 16'h0);
    step(0, 1, 16'h0010, 0, 16'h0);
    step(0, 0, 16'h0, 1, 16'hF000);
    step(1, 1, 16'h0200, 0, 16'h0);
    chk("cancel_addr", bus.imem_addr, 16'h0200);
    repeat (3) step(0, 0, 16'h0, 1, seq_word(m_pc));
    chk("cancel_halted", 16'(bus.halted), 16'd0);

    // PC wrap.
    step(0, 1, 16'hFFFE, 0, 16'h0);
    step(0, 0, 16'h0, 1, 16'h1234);
    chk("wrap_addr", bus.imem_addr, 16'h0000);
    repeat (2) step(0, 0, 16'h0, 1, seq_word(m_pc));

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("areset_valid", 16'(bus.if_valid), 16'd0);
    chk("areset_instr", bus.if_instr, 16'h0000);
    chk("areset_count", bus.fetch_count, 16'h0000);
    chk("areset_addr",  bus.imem_addr, 16'h0000);
    chk("areset_req",   16'(bus.imem_req), 16'd0);
    do_reset(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(1 + int'($urandom_range(0, 1)));
      end else begin
        d = 16'($urandom);
        if ($urandom_range(0, 99) < 4) d[15:12] = 4'hF;
        else if (d[15:12] == 4'hF) d[15:12] = 4'h0;
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
             16'($urandom), $urandom_range(0, 99) < 70, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
